// File: rtl/floo_ring_on_mesh_mcast_inject_pkg.sv
// Shared types for the ring-on-mesh multicast injection encoder.
// Provides the default flit layout (header + payload) and the ring id type
// used by floo_ring_on_mesh_mcast_inject and its replay buffer.
//   ring_id_t   : ring position / destination id type
//   ring_mask_t : one bit per ring node, multicast destination mask
//   ring_hdr_t  : flit header carrying the fields the encoder rewrites
//   ring_flit_t : header plus opaque payload
package floo_ring_on_mesh_mcast_inject_pkg;

  localparam int unsigned DefaultRingNodes = 8;
  localparam int unsigned IdWidth          = 6;
  localparam int unsigned PayloadWidth     = 32;

  typedef logic [IdWidth-1:0]          ring_id_t;
  typedef logic [DefaultRingNodes-1:0] ring_mask_t;

  typedef struct packed {
    ring_id_t   dst_id;
    ring_id_t   src_id;
    logic       last;
    logic       ring_on_mesh_mcast;
    logic       up_down_traffic;
    ring_mask_t ring_on_mesh_dst_mask;
  } ring_hdr_t;

  typedef struct packed {
    ring_hdr_t                hdr;
    logic [PayloadWidth-1:0]  payload;
  } ring_flit_t;

endpackage

// File: rtl/floo_ring_mcast_replay_buf.sv
// Replay buffer for the down copy of a two-direction multicast burst.
// Flits are written in order while the up copy streams out and read back in
// the same order afterwards. The read data comes straight from flops, so it
// is stable while the consumer stalls.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : return both pointers and the count to zero
//   wr_en_i       : store wr_data_i at the write pointer
//   wr_data_i     : flit to store
//   rd_en_i       : advance the read pointer
//   rd_data_o     : flit at the read pointer
//   count_o       : number of stored, not yet read flits
module floo_ring_mcast_replay_buf
  import floo_ring_on_mesh_mcast_inject_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter type         data_t = ring_flit_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  data_t                        wr_data_i,
  input  logic                         rd_en_i,
  output data_t                        rd_data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  data_t            mem_q [Depth];
  data_t            mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Pointer and storage update; a clear wins over any concurrent access so
  // the next burst always starts at entry 0.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en_i) begin
      mem_d[wr_ptr_q] = wr_data_i;
    end
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_en_i) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(wr_en_i) - CntW'(rd_en_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/floo_ring_on_mesh_mcast_inject.sv
// Source-side multicast encoder for ring-on-mesh traffic. Sits between a
// chimney's outgoing flit stream and the router local port and turns each
// multicast burst into at most two ring traversals: an up copy addressed to
// the farthest up target and a down copy addressed to the farthest down
// target. Bursts needing both directions stream up while being captured and
// are then replayed down from a local buffer; the two copies never interleave.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   ring_id_i         : this node's ring position (quasi-static)
//   valid_i/ready_o   : input flit handshake, data_i input flit
//   valid_o/ready_i   : output flit handshake to router, data_o output flit
//   drop_o            : pulse per accepted flit of a burst with no target
module floo_ring_on_mesh_mcast_inject
  import floo_ring_on_mesh_mcast_inject_pkg::*;
#(
  parameter int unsigned NumRingNodes = 8,
  parameter int unsigned BufDepth     = 4,
  parameter type         flit_t       = floo_ring_on_mesh_mcast_inject_pkg::ring_flit_t,
  parameter type         id_t         = floo_ring_on_mesh_mcast_inject_pkg::ring_id_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  id_t   ring_id_i,
  input  logic  valid_i,
  output logic  ready_o,
  input  flit_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output flit_t data_o,
  output logic  drop_o
);

  localparam int unsigned CntW = $clog2(BufDepth + 1);
  localparam logic [CntW-1:0] BufFull = CntW'(BufDepth);

  typedef enum logic [2:0] {
    StIdle,
    StBypass,
    StUpOnly,
    StDownOnly,
    StUpCapture,
    StReplay,
    StDrop
  } state_e;

  state_e state_q, state_d;
  state_e first_mode;
  state_e mode;

  logic [NumRingNodes-1:0] in_mask, up_mask, down_mask, out_mask;
  logic                    need_up, need_down;
  id_t                     up_tgt, down_tgt;
  id_t                     up_tgt_q, up_tgt_d;
  id_t                     down_tgt_q, down_tgt_d;
  id_t                     up_tgt_eff, down_tgt_eff;

  flit_t                   up_copy, down_copy, replay_copy;
  flit_t                   buf_rd_data;
  logic [CntW-1:0]         buf_count;
  logic                    buf_wr, buf_rd, buf_clr;
  logic                    in_hs;

  assign in_mask = data_i.hdr.ring_on_mesh_dst_mask;

  // Split the mask around our own position. The self bit feeds neither half
  // and is removed from every emitted copy. Up target is the highest set
  // index above us, down target the lowest set index below us.
  always_comb begin
    up_mask   = '0;
    down_mask = '0;
    out_mask  = in_mask;
    for (int i = 0; i < int'(NumRingNodes); i++) begin
      if (id_t'(i) > ring_id_i) begin
        up_mask[i] = in_mask[i];
      end else if (id_t'(i) < ring_id_i) begin
        down_mask[i] = in_mask[i];
      end else begin
        out_mask[i] = 1'b0;
      end
    end
    up_tgt = '0;
    for (int i = 0; i < int'(NumRingNodes); i++) begin
      if (up_mask[i]) begin
        up_tgt = id_t'(i);
      end
    end
    down_tgt = '0;
    for (int i = int'(NumRingNodes) - 1; i >= 0; i--) begin
      if (down_mask[i]) begin
        down_tgt = id_t'(i);
      end
    end
  end

  assign need_up   = |up_mask;
  assign need_down = |down_mask;

  // Mode a burst would take if data_i were its first flit.
  always_comb begin
    if (!data_i.hdr.ring_on_mesh_mcast) begin
      first_mode = StBypass;
    end else if (need_up && need_down) begin
      first_mode = StUpCapture;
    end else if (need_up) begin
      first_mode = StUpOnly;
    end else if (need_down) begin
      first_mode = StDownOnly;
    end else begin
      first_mode = StDrop;
    end
  end

  // IDLE handles the first flit in the mode it decodes to, using live
  // targets; later flits use the mode and targets latched at that handshake.
  assign mode         = (state_q == StIdle) ? first_mode : state_q;
  assign up_tgt_eff   = (state_q == StIdle) ? up_tgt     : up_tgt_q;
  assign down_tgt_eff = (state_q == StIdle) ? down_tgt   : down_tgt_q;

  always_comb begin
    up_copy                           = data_i;
    up_copy.hdr.ring_on_mesh_dst_mask = out_mask;
    up_copy.hdr.dst_id                = up_tgt_eff;
    up_copy.hdr.up_down_traffic       = 1'b1;

    down_copy                           = data_i;
    down_copy.hdr.ring_on_mesh_dst_mask = out_mask;
    down_copy.hdr.dst_id                = down_tgt_eff;
    down_copy.hdr.up_down_traffic       = 1'b0;

    replay_copy                     = buf_rd_data;
    replay_copy.hdr.dst_id          = down_tgt_q;
    replay_copy.hdr.up_down_traffic = 1'b0;
  end

  // State register together with the per-burst latched targets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      up_tgt_q   <= '0;
      down_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      up_tgt_q   <= up_tgt_d;
      down_tgt_q <= down_tgt_d;
    end
  end

  assign in_hs = valid_i && ready_o;

  // Next-state logic. A single-flit burst stays in IDLE unless it still owes
  // a down copy, in which case it goes straight to REPLAY.
  always_comb begin
    state_d    = state_q;
    up_tgt_d   = up_tgt_q;
    down_tgt_d = down_tgt_q;
    case (state_q)
      StIdle: begin
        if (in_hs) begin
          up_tgt_d   = up_tgt;
          down_tgt_d = down_tgt;
          if (data_i.hdr.last) begin
            state_d = (first_mode == StUpCapture) ? StReplay : StIdle;
          end else begin
            state_d = first_mode;
          end
        end
      end
      StBypass, StUpOnly, StDownOnly, StDrop: begin
        if (in_hs && data_i.hdr.last) begin
          state_d = StIdle;
        end
      end
      StUpCapture: begin
        if (in_hs && data_i.hdr.last) begin
          state_d = StReplay;
        end
      end
      StReplay: begin
        if (ready_i && buf_rd_data.hdr.last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic. Streaming modes are a combinational pass-through with the
  // header rewritten; REPLAY holds off the input while draining the buffer.
  // drop_o is forced low while reset is asserted.
  always_comb begin
    valid_o = valid_i;
    ready_o = ready_i;
    data_o  = data_i;
    drop_o  = 1'b0;
    buf_wr  = 1'b0;
    buf_rd  = 1'b0;
    buf_clr = 1'b0;
    case (mode)
      StUpOnly: begin
        data_o = up_copy;
      end
      StDownOnly: begin
        data_o = down_copy;
      end
      StUpCapture: begin
        data_o = up_copy;
        buf_wr = valid_i && ready_i;
      end
      StDrop: begin
        valid_o = 1'b0;
        ready_o = 1'b1;
        drop_o  = valid_i && rst_ni;
      end
      StReplay: begin
        valid_o = 1'b1;
        ready_o = 1'b0;
        data_o  = replay_copy;
        buf_rd  = ready_i;
        buf_clr = ready_i && buf_rd_data.hdr.last;
      end
      default: begin
        data_o = data_i;
      end
    endcase
  end

  floo_ring_mcast_replay_buf #(
    .Depth  (BufDepth),
    .data_t (flit_t)
  ) i_replay_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (up_copy),
    .rd_en_i   (buf_rd),
    .rd_data_o (buf_rd_data),
    .count_o   (buf_count)
  );

  // A burst longer than the buffer would overwrite flits not yet replayed.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(buf_wr && (buf_count == BufFull)));

endmodule

// File: tb/tb_floo_ring_on_mesh_mcast_inject.sv
// Self-checking bench for floo_ring_on_mesh_mcast_inject. Bursts are built
// in the bench, a reference model expands each burst into the expected
// output flits (up copy then down copy, or pass-through, or drop), and a
// monitor compares every output handshake against that expectation queue.
module tb_floo_ring_on_mesh_mcast_inject;
  import floo_ring_on_mesh_mcast_inject_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  ring_id_t   ring_id;
  logic       valid_i, ready_o, valid_o, ready_i, drop_o;
  ring_flit_t data_i, data_o;

  int checks = 0;
  int errors = 0;

  ring_flit_t exp_q[$];
  ring_flit_t burst_q[$];
  ring_flit_t first_exp;
  ring_flit_t mon_exp;
  ring_flit_t prev_data;
  logic       first_exp_vld;
  logic       model_drop;
  logic       stall_en;
  logic       prev_stall;
  int         drop_exp = 0;
  int         drop_seen = 0;
  int         out_cnt = 0;

  floo_ring_on_mesh_mcast_inject #(
    .NumRingNodes (8),
    .BufDepth     (4),
    .flit_t       (ring_flit_t),
    .id_t         (ring_id_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ring_id_i (ring_id),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .drop_o    (drop_o)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: expand burst_q into expected output flits.
  function automatic void modelBurst(input int rid);
    int         up_t;
    int         dn_t;
    logic [7:0] m0;
    ring_flit_t f;
    up_t = -1;
    dn_t = -1;
    first_exp_vld = 1'b0;
    model_drop = 1'b0;
    m0 = burst_q[0].hdr.ring_on_mesh_dst_mask;
    for (int i = 0; i < 8; i++) begin
      if (m0[i] && i > rid) up_t = i;
      if (m0[i] && i < rid && dn_t < 0) dn_t = i;
    end
    if (!burst_q[0].hdr.ring_on_mesh_mcast) begin
      foreach (burst_q[k]) exp_q.push_back(burst_q[k]);
    end else if (up_t < 0 && dn_t < 0) begin
      drop_exp += burst_q.size();
      model_drop = 1'b1;
    end else begin
      if (up_t >= 0) begin
        foreach (burst_q[k]) begin
          f = burst_q[k];
          f.hdr.ring_on_mesh_dst_mask[rid] = 1'b0;
          f.hdr.dst_id = ring_id_t'(up_t);
          f.hdr.up_down_traffic = 1'b1;
          exp_q.push_back(f);
        end
      end
      if (dn_t >= 0) begin
        foreach (burst_q[k]) begin
          f = burst_q[k];
          f.hdr.ring_on_mesh_dst_mask[rid] = 1'b0;
          f.hdr.dst_id = ring_id_t'(dn_t);
          f.hdr.up_down_traffic = 1'b0;
          exp_q.push_back(f);
        end
      end
    end
    if (exp_q.size() > 0) begin
      first_exp = exp_q[0];
      first_exp_vld = 1'b1;
    end
  endfunction

  // Build one burst, feed it to the model and drive it with valid/ready.
  task automatic applyStimulus(input int rid, input int len, input logic mcast,
                               input logic [7:0] mask, input logic same_mask,
                               input int dst);
    ring_flit_t f;
    logic       hs;
    int         guard;
    burst_q.delete();
    for (int k = 0; k < len; k++) begin
      f.payload = $urandom;
      f.hdr.dst_id = (dst >= 0) ? ring_id_t'(dst) : ring_id_t'($urandom_range(0, 63));
      f.hdr.src_id = ring_id_t'($urandom_range(0, 63));
      f.hdr.last = (k == len - 1);
      f.hdr.ring_on_mesh_mcast = mcast;
      f.hdr.up_down_traffic = 1'($urandom_range(0, 1));
      f.hdr.ring_on_mesh_dst_mask = (k == 0 || same_mask) ? mask : 8'($urandom);
      burst_q.push_back(f);
    end
    ring_id = ring_id_t'(rid);
    modelBurst(rid);
    for (int k = 0; k < len; k++) begin
      valid_i = 1'b1;
      data_i = burst_q[k];
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 200) begin
        @(negedge clk);
        if (k == 0 && guard == 0 && first_exp_vld) begin
          checkOutput("zero_latency_valid", 64'(valid_o), 64'(1'b1));
          checkOutput("zero_latency_data", 64'(data_o), 64'(first_exp));
        end
        if (model_drop) begin
          checkOutput("drop_ready_o", 64'(ready_o), 64'(1'b1));
          checkOutput("drop_valid_o", 64'(valid_o), 64'(1'b0));
        end
        hs = ready_o;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!hs) checkOutput("in_handshake_timeout", 64'(hs), 64'(1'b1));
    end
    valid_i = 1'b0;
  endtask

  task automatic drainAndCheck();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    #1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'(0));
    checkOutput("drop_count", 64'(drop_seen), 64'(drop_exp));
  endtask

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on every handshake plus stall stability.
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (prev_stall) begin
          checkOutput("stall_valid_o", 64'(valid_o), 64'(1'b1));
          checkOutput("stall_data_o", 64'(data_o), 64'(prev_data));
        end
        if (drop_o) drop_seen++;
        if (valid_o && ready_i) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_flit_pending", 64'(exp_q.size()), 64'(1));
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("out_flit", 64'(data_o), 64'(mon_exp));
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_data = data_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int guard;
    rst_n = 1'b0;
    valid_i = 1'b0;
    data_i = '0;
    ring_id = ring_id_t'(3);
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Self-only multicast flit presented during reset must not pulse drop_o.
    data_i.hdr.ring_on_mesh_mcast = 1'b1;
    data_i.hdr.ring_on_mesh_dst_mask = 8'h08;
    valid_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid_o", 64'(valid_o), 64'(1'b0));
    checkOutput("rst_drop_o", 64'(drop_o), 64'(1'b0));
    checkOutput("rst_ready_o", 64'(ready_o), 64'(1'b1));
    valid_i = 1'b0;
    data_i = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Up and down copy from one flit; input blocked during the replay flit.
    applyStimulus(3, 1, 1'b1, 8'hA6, 1'b1, -1);
    @(negedge clk);
    checkOutput("replay_ready_o", 64'(ready_o), 64'(1'b0));
    checkOutput("replay_valid_o", 64'(valid_o), 64'(1'b1));
    drainAndCheck();

    // Up only, self bit cleared, no replay afterwards.
    applyStimulus(3, 1, 1'b1, 8'h38, 1'b1, -1);
    @(negedge clk);
    checkOutput("no_replay_ready_o", 64'(ready_o), 64'(1'b1));
    checkOutput("no_replay_valid_o", 64'(valid_o), 64'(1'b0));
    drainAndCheck();

    // Self-only mask is dropped.
    applyStimulus(3, 1, 1'b1, 8'h08, 1'b1, -1);
    drainAndCheck();

    // Unicast passes unchanged.
    applyStimulus(3, 1, 1'b0, 8'h5A, 1'b1, 42);
    drainAndCheck();

    // Four-flit burst to both ends with random output stalls.
    stall_en = 1'b1;
    applyStimulus(3, 4, 1'b1, 8'h81, 1'b1, -1);
    drainAndCheck();

    // Randomised bursts across ring positions, lengths and masks.
    for (int n = 0; n < 30; n++) begin
      stall_en = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 7), $urandom_range(1, 4),
                    ($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 1)), -1);
      drainAndCheck();
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a replay abandons the remaining down copy.
    base = out_cnt;
    applyStimulus(3, 4, 1'b1, 8'h81, 1'b1, -1);
    guard = 0;
    while (out_cnt < base + 6 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    checkOutput("replayed_before_reset", 64'(out_cnt - base), 64'(6));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midrst_valid_o", 64'(valid_o), 64'(1'b0));
    checkOutput("midrst_ready_o", 64'(ready_o), 64'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(5, 1, 1'b0, 8'h81, 1'b1, -1);
    drainAndCheck();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
